// File: rtl/seq_detector_param.sv
// seq_detector_param: run-time programmable serial pattern detector.
// Accepts qualified bits, compares the last len_q bits (including the bit
// being accepted) against a programmed pattern, and emits a registered
// one-cycle detect pulse plus a saturating match count. Overlapping or
// non-overlapping matching is selected at configuration time.
module seq_detector_param #(
  parameter int N     = 8,
  parameter int CNT_W = 8,
  parameter int LEN_W = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             x,
  input  logic             x_valid,
  input  logic             cfg_load,
  input  logic [N-1:0]     cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  output logic             z,
  output logic [CNT_W-1:0] match_cnt
);

  // Registered configuration
  logic [N-1:0]     pat_q, pat_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             ovl_q, ovl_d;

  // Detection state. Only N-1 history bits are stored: the comparison window
  // is at most N bits and always includes the incoming bit, so the oldest
  // bit of an N-bit history can never influence a match.
  logic [N-2:0]     hist_q, hist_d;
  logic [LEN_W-1:0] fill_q, fill_d;
  logic             z_q, z_d;
  logic [CNT_W-1:0] match_cnt_q, match_cnt_d;

  // Combinational match helpers
  logic [N-1:0]     window;
  logic [N-1:0]     len_mask;
  logic [LEN_W:0]   fill_inc;
  logic [LEN_W-1:0] fill_sat;
  logic [LEN_W-1:0] len_clamped;
  logic             fill_ok;
  logic             pat_eq;
  logic             match_now;

  // Compare the newest len_q bits (incoming bit included) with the pattern
  always_comb begin
    window   = {hist_q, x};
    len_mask = '0;
    for (int unsigned i = 0; i < N; i++) begin
      len_mask[i] = (i < 32'(len_q));
    end
    fill_inc    = {1'b0, fill_q} + (LEN_W + 1)'(1);
    fill_sat    = (fill_q == LEN_W'(N)) ? fill_q : fill_inc[LEN_W-1:0];
    fill_ok     = (fill_inc >= {1'b0, len_q});
    pat_eq      = (((window ^ pat_q) & len_mask) == '0);
    match_now   = x_valid & (len_q != '0) & fill_ok & pat_eq;
    len_clamped = (cfg_len > LEN_W'(N)) ? LEN_W'(N) : cfg_len;
  end

  // Next-state: configuration load has priority over bit acceptance
  always_comb begin
    pat_d       = pat_q;
    len_d       = len_q;
    ovl_d       = ovl_q;
    hist_d      = hist_q;
    fill_d      = fill_q;
    z_d         = 1'b0;
    match_cnt_d = match_cnt_q;

    if (cfg_load) begin
      pat_d       = cfg_pattern;
      len_d       = len_clamped;
      ovl_d       = cfg_overlap;
      hist_d      = '0;
      fill_d      = '0;
      match_cnt_d = '0;
    end else if (x_valid) begin
      hist_d = window[N-2:0];
      fill_d = fill_sat;
      if (match_now) begin
        z_d = 1'b1;
        if (match_cnt_q != '1) begin
          match_cnt_d = match_cnt_q + CNT_W'(1);
        end
        if (!ovl_q) begin
          fill_d = '0;
        end
      end
    end
  end

  // State register with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pat_q       <= '0;
      len_q       <= '0;
      ovl_q       <= 1'b1;
      hist_q      <= '0;
      fill_q      <= '0;
      z_q         <= 1'b0;
      match_cnt_q <= '0;
    end else begin
      pat_q       <= pat_d;
      len_q       <= len_d;
      ovl_q       <= ovl_d;
      hist_q      <= hist_d;
      fill_q      <= fill_d;
      z_q         <= z_d;
      match_cnt_q <= match_cnt_d;
    end
  end

  assign z         = z_q;
  assign match_cnt = match_cnt_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: directed scenarios plus random traffic,
// checked every cycle against a bit-queue model of the matching rules.
module tb_seq_detector_param;

  localparam int N     = 8;
  localparam int LEN_W = $clog2(N + 1);

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             x = 1'b0;
  logic             x_valid = 1'b0;
  logic             cfg_load = 1'b0;
  logic [N-1:0]     cfg_pattern = '0;
  logic [LEN_W-1:0] cfg_len = '0;
  logic             cfg_overlap = 1'b0;
  logic             z, z_s;
  logic [7:0]       match_cnt;
  logic [1:0]       match_cnt_s;

  int n_checks = 0;
  int n_errors = 0;

  seq_detector_param #(.N(N), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .x(x), .x_valid(x_valid), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .z(z), .match_cnt(match_cnt)
  );

  seq_detector_param #(.N(N), .CNT_W(2)) dut_s (
    .clk(clk), .reset(reset), .x(x), .x_valid(x_valid), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .z(z_s), .match_cnt(match_cnt_s)
  );

  always #5 clk = ~clk;

  // Reference model: accepted bits kept in a queue, newest at the back
  bit         q[$];
  int         fresh;
  int         m_tot;
  bit         m_z;
  logic [N-1:0] m_pat;
  int         m_len;
  bit         m_ovl;

  task automatic model_reset();
    q.delete();
    fresh = 0;
    m_tot = 0;
    m_z   = 0;
    m_pat = '0;
    m_len = 0;
    m_ovl = 1;
  endtask

  task automatic model_step();
    bit hit;
    if (!reset) begin
      model_reset();
    end else if (cfg_load) begin
      m_pat = cfg_pattern;
      m_len = (int'(cfg_len) > N) ? N : int'(cfg_len);
      m_ovl = cfg_overlap;
      q.delete();
      fresh = 0;
      m_tot = 0;
      m_z   = 0;
    end else if (x_valid) begin
      q.push_back(x);
      if (q.size() > N) void'(q.pop_front());
      fresh++;
      hit = (m_len != 0) && (fresh >= m_len);
      for (int k = 0; k < m_len; k++) begin
        if (hit && (q[q.size() - 1 - k] != m_pat[k])) hit = 0;
      end
      m_z = hit;
      if (hit) begin
        m_tot++;
        if (!m_ovl) fresh = 0;
      end
    end else begin
      m_z = 0;
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // Per-cycle comparison of both instances against the model
  always @(negedge clk) begin
    chk("z", int'(z), int'(m_z));
    chk("cnt", int'(match_cnt), (m_tot > 255) ? 255 : m_tot);
    chk("z_s", int'(z_s), int'(m_z));
    chk("cnt_s", int'(match_cnt_s), (m_tot > 3) ? 3 : m_tot);
  end

  // One clock of stimulus; model advances on the same edge as the DUT
  task automatic cyc(input logic r, input logic ld, input logic v, input logic xb);
    @(negedge clk);
    #1;
    reset    = r;
    cfg_load = ld;
    x_valid  = v;
    x        = xb;
    if (!r) model_reset();
    @(posedge clk);
    model_step();
  endtask

  task automatic load(input logic [N-1:0] p, input logic [LEN_W-1:0] l, input logic o);
    cfg_pattern = p;
    cfg_len     = l;
    cfg_overlap = o;
    cyc(1'b1, 1'b1, 1'b1, 1'($urandom));
  endtask

  // Feed n bits (bits[n-1] first) and pin z after each against ez
  task automatic feed(input string nm, input logic [15:0] bits, input int n,
                      input logic [15:0] ez, input int ecnt, input bit gaps);
    int g;
    for (int i = n - 1; i >= 0; i--) begin
      if (gaps) begin
        g = $urandom_range(1, 2);
        for (int k = 0; k < g; k++) begin
          cyc(1'b1, 1'b0, 1'b0, 1'($urandom));
          #1;
          chk({nm, "_gap_z"}, int'(z), 0);
        end
      end
      cyc(1'b1, 1'b0, 1'b1, bits[i]);
      #1;
      chk({nm, "_z"}, int'(z), int'(ez[i]));
      chk({nm, "_model_z"}, int'(m_z), int'(ez[i]));
    end
    chk({nm, "_cnt"}, int'(match_cnt), ecnt);
    chk({nm, "_model_cnt"}, m_tot, ecnt);
  endtask

  initial begin
    int r;
    model_reset();

    // Reset held with random input activity
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b0, 1'($urandom), 1'($urandom));
      #1;
      chk("rst_z", int'(z), 0);
      chk("rst_cnt", int'(match_cnt), 0);
    end
    feed("disabled", 16'b1111, 4, 16'b0000, 0, 0);

    load(8'b101, 4'd3, 1'b1);
    feed("ovl", 16'b10101, 5, 16'b00101, 2, 0);

    load(8'b101, 4'd3, 1'b0);
    feed("novl", 16'b10101, 5, 16'b00100, 1, 0);
    feed("novl2", 16'b01, 2, 16'b01, 2, 0);

    load(8'b1101, 4'd4, 1'b1);
    feed("len4", 16'b1101101, 7, 16'b0001001, 2, 0);

    load(8'b10110011, 4'd15, 1'b1);
    #1;
    chk("clamp_len", int'(dut.len_q), 8);
    feed("clamp", 16'b10110011, 8, 16'b00000001, 1, 0);

    load(8'b101, 4'd3, 1'b1);
    feed("gap", 16'b10101, 5, 16'b00101, 2, 1);

    // Load coinciding with the final pattern bit discards that bit
    load(8'b101, 4'd3, 1'b1);
    feed("ld_pre", 16'b10, 2, 16'b00, 0, 0);
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    #1;
    chk("ld_final_z", int'(z), 0);
    chk("ld_final_cnt", int'(match_cnt), 0);
    feed("ld_post", 16'b01, 2, 16'b00, 0, 0);

    // Reset mid-pattern
    load(8'b101, 4'd3, 1'b1);
    feed("rst_pre", 16'b10, 2, 16'b00, 0, 0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    feed("rst_post", 16'b1, 1, 16'b0, 0, 0);

    // Five overlapping matches: narrow counter saturates at 3
    load(8'b101, 4'd3, 1'b1);
    feed("sat", 16'b10101010101, 11, 16'b00101010101, 5, 0);
    chk("sat_cnt_s", int'(match_cnt_s), 3);

    // Random traffic with occasional reconfiguration and reset
    for (int c = 0; c < 4000; c++) begin
      r = $urandom_range(0, 999);
      if (r < 4) begin
        cyc(1'b0, 1'b0, 1'($urandom), 1'($urandom));
      end else if (r < 30) begin
        cfg_pattern = N'($urandom);
        if ($urandom_range(0, 3) == 0) cfg_len = LEN_W'($urandom);
        else cfg_len = LEN_W'($urandom_range(1, 4));
        cfg_overlap = 1'($urandom);
        cyc(1'b1, 1'b1, 1'($urandom), 1'($urandom));
      end else begin
        cyc(1'b1, 1'b0, ($urandom_range(0, 3) != 0), 1'($urandom));
      end
    end

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seq_detector_param.md
# seq_detector_param

Parametrised serial bit-pattern detector: the run-time-programmable successor to the fixed "101" Moore detectors. It samples a qualified serial bit stream and asserts a registered, Moore-style one-cycle detect pulse whenever the last `len` accepted bits equal a programmed pattern. Overlapping or non-overlapping matching is selectable. It also keeps a saturating match counter. It sits between a serial front-end (UART/line decoder) and control logic that reacts to framing or sync words.

## Interface
- `N`, 8, maximum pattern length in bits (N ≥ 2)
- `CNT_W`, 8, width of the match counter
- `LEN_W`, $clog2(N+1), width of the length field (derived; not for override)

- `clk`  in  1  clock, all state updates on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `x`  in  1  serial data bit
- `x_valid`  in  1  qualifies `x`; a bit is accepted only on edges where `x_valid`=1
- `cfg_load`  in  1  one-cycle strobe that latches `cfg_pattern`, `cfg_len` and `cfg_overlap`, and clears detection state
- `cfg_pattern`  in  N  pattern; `cfg_pattern[len-1]` is the first bit received, `cfg_pattern[0]` is the last
- `cfg_len`  in  LEN_W  pattern length
- `cfg_overlap`  in  1  1 = overlapping detection, 0 = non-overlapping
- `z`  out  1  registered detect pulse
- `match_cnt`  out  CNT_W  saturating count of detections

## Operation
- Registered config: `pat_r`, `len_r`, `ovl_r`.
  - Reset values: `pat_r`=0, `len_r`=0, `ovl_r`=1.
  - On `cfg_load`, `len_r` latches as follows: `cfg_len`>N is clamped to N; `cfg_len`=0 is kept as 0 and means the detector is disabled.
- Detection state:
  - History shift register `hist[N-1:0]`. On each accepted bit: `hist <= {hist[N-2:0], x}`, so `hist[0]` is the newest bit.
  - Fill counter `fill` (0..N, saturates at N). Counts accepted bits since the last clear.
- Combinational match: `match_now = x_valid & (len_r≠0) & (fill+1 ≥ len_r) & ({hist[N-2:0],x}[len_r-1:0] == pat_r[len_r-1:0])`. The comparison includes the bit being accepted this edge.
- On an edge with `match_now`=1:
  - `z <= 1`.
  - `match_cnt` increments, saturating at 2^CNT_W−1.
  - If `ovl_r`=0, `fill` resets to 0 (history contents are kept but ignored), so the next match needs `len_r` fresh bits.
  - If `ovl_r`=1, `fill` continues.
- On any edge with `match_now`=0: `z <= 0`. `z` is never high for two consecutive cycles unless two consecutive accepted bits each complete a match.
- On an edge with `x_valid`=0: `hist` and `fill` hold, and `z <= 0`.
- On `cfg_load`=1, which has priority over `x_valid`:
  - Config is latched.
  - `hist`, `fill`, `z` and `match_cnt` clear to 0.
  - Any bit presented that edge is discarded.
- On `reset` asserted, at any time including mid-pattern, all registers go to their reset values immediately: `z`=0, `match_cnt`=0, `hist`=0, `fill`=0, config as listed above.

## Timing
- Detection latency: `z` rises on the edge that accepts the final pattern bit. It is visible for exactly the following clock cycle.
- `match_cnt` updates on the same edge as `z`.
- New config applies to bits accepted from the edge after `cfg_load`.
- Outputs depend only on registers (Moore). There is no combinational path from `x` to `z`.
- Release of `reset` is synchronous to `clk` in the system. The first bit can be accepted on the first edge after deassertion.

## Test plan
- Reset check: assert `reset` with random `x` → `z`=0, `match_cnt`=0. After release, with no `cfg_load`, the stream 1111 → no `z` (`len_r`=0, detector disabled).
- Overlapping "101" (`cfg_pattern`=…101, `len`=3, `overlap`=1), stream 1,0,1,0,1 with `x_valid`=1 → `z` pulses after the 3rd and 5th bits; `match_cnt`=2.
- Non-overlapping "101", same stream → `z` only after the 3rd bit; `match_cnt`=1. Then stream 0,1 → `z` after the 7th bit; `match_cnt`=2.
- Length and clamp checks:
  - `len`=4, pattern 1101, stream 1,1,0,1,1,0,1 with `overlap`=1 → `z` after the 4th and 7th bits.
  - `cfg_len`=15 with N=8 → `len_r` latches as 8.
- `x_valid` gaps: "101" with `x_valid`=0 cycles inserted between bits, and `x` toggling during the gaps → same detections as the ungapped stream. `z` is low during gap cycles.
- Mid-stream events:
  - `cfg_load` asserted together with the final bit of a pattern → no `z`, `match_cnt`=0, and the bit is discarded.
  - `reset` pulsed after 2 of 3 bits → the next single bit 1 does not produce `z`.
  - With `CNT_W`=2, five matches → `match_cnt` saturates at 3.
